mem_bus_arbiter: RTL and testbench

- Shares the single memory port (Memread / 2-bit Memwrite / 32-bit Addr, synchronous Mem) between two requesters: the CPU and the VGA framebuffer fetcher.
- Sits between CPU/VGA and Mem in the PC top level and replaces the direct CPU→Mem hookup.
- Serialises accesses, holds address/data for the memory latency, and returns read data plus a one-cycle ack to the winner.
- VGA has priority for display deadlines; a starvation counter guarantees CPU forward progress.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared memory-bus definitions: Memwrite codes, arbiter states, owner encoding.
package bus_pkg;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_BYTE = 2'b01,
        MW_HALF = 2'b10,
        MW_WORD = 2'b11
    } mw_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_VGA = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU / VGA) arbiter for the single synchronous memory port.
// VGA has priority; a starvation counter forces a CPU win after STARVE_MAX VGA wins.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [1:0]    cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_rdata,
    output logic          vga_ack,
    output logic          mem_read,
    output logic [1:0]    mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    localparam int LW       = $clog2(MEM_LAT + 1);
    localparam int SW       = $clog2(STARVE_MAX + 1);
    localparam int LAT_INIT = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] vga_rdata_q, vga_rdata_d;
    logic          capture;
    logic          cpu_forced;

    assign cpu_forced = cpu_req && (starve_q == SW'(STARVE_MAX));
    assign owner      = owner_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign vga_rdata  = vga_rdata_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        vga_rdata_d = vga_rdata_q;
        capture     = 1'b0;
        cpu_ack     = 1'b0;
        vga_ack     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = MW_NONE;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            IDLE: begin
                if (vga_req && !cpu_forced) begin
                    owner_d = OWN_VGA;
                    addr_d  = vga_addr;
                    we_d    = MW_NONE;
                    wdata_d = '0;
                    if (cpu_req && starve_q < SW'(STARVE_MAX))
                        starve_d = starve_q + SW'(1);
                    state_d = ISSUE;
                end else if (cpu_req) begin
                    owner_d  = OWN_CPU;
                    addr_d   = cpu_addr;
                    we_d     = cpu_we;
                    wdata_d  = cpu_wdata;
                    starve_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr = addr_q;
                if (we_q == MW_NONE) begin
                    mem_read = 1'b1;
                    if (MEM_LAT == 1) begin
                        capture = 1'b1;
                        state_d = ACK;
                    end else begin
                        lat_d   = LW'(LAT_INIT);
                        state_d = WAIT;
                    end
                end else begin
                    // Writes complete in one cycle regardless of read latency.
                    mem_write = we_q;
                    mem_wdata = wdata_q;
                    state_d   = ACK;
                end
            end
            WAIT: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                if (lat_q == '0) begin
                    capture = 1'b1;
                    state_d = ACK;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            ACK: begin
                cpu_ack = (owner_q == OWN_CPU);
                vga_ack = (owner_q == OWN_VGA);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            if (owner_q == OWN_VGA) vga_rdata_d = mem_rdata;
            else                    cpu_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            addr_q      <= '0;
            we_q        <= MW_NONE;
            wdata_q     <= '0;
            lat_q       <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_rdata_q <= vga_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic against a
// transaction-phase reference model.
module tb_mem_bus_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MEM_LAT    = 3;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0;
    logic [1:0]    cpu_we = 2'b00;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_rdata;
    logic          vga_ack;
    logic          mem_read;
    logic [1:0]    mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          owner;
    logic [31:0]   salt = 32'h0;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_ack(vga_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory content is a function of the address so the model can predict it.
    assign mem_rdata = mem_read ? (mem_addr ^ salt) : '0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: ph counts cycles since grant (0 = idle), ack when ph == lat.
    int          ph = 0;
    int          lat = 0;
    bit          m_own = 1'b0;
    bit          m_rd = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wd = '0;
    logic [1:0]  m_we = '0;
    int          starve = 0;
    logic [31:0] e_crd = '0;
    logic [31:0] e_vrd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ack(input bit who);
        return (ph != 0) && (ph == lat) && (m_own == who);
    endfunction

    task automatic model_reset();
        ph = 0; lat = 0; m_own = 1'b0; m_rd = 1'b0; m_addr = '0; m_wd = '0; m_we = '0;
        starve = 0; e_crd = '0; e_vrd = '0;
    endtask

    task automatic model_edge();
        bit cpu_wins;
        if (ph == 0) begin
            if (cpu_req || vga_req) begin
                cpu_wins = cpu_req && (!vga_req || starve == STARVE_MAX);
                if (cpu_wins) begin
                    m_own = 1'b0; m_addr = cpu_addr; m_we = cpu_we; m_wd = cpu_wdata; starve = 0;
                end else begin
                    m_own = 1'b1; m_addr = vga_addr; m_we = 2'b00; m_wd = '0;
                    if (cpu_req && starve < STARVE_MAX) starve++;
                end
                m_rd = (m_we == 2'b00);
                lat  = m_rd ? 1 + MEM_LAT : 2;
                ph   = 1;
            end
        end else if (ph == lat) begin
            ph = 0;
        end else begin
            ph++;
        end
        if (ph != 0 && ph == lat && m_rd) begin
            if (m_own) e_vrd = m_addr ^ salt;
            else       e_crd = m_addr ^ salt;
        end
    endtask

    task automatic check_all();
        bit busy;
        bit wr_issue;
        busy     = (ph >= 1) && (ph < lat);
        wr_issue = (ph == 1) && !m_rd;
        chk("mem_read",  mem_read,  busy && m_rd);
        chk("mem_write", mem_write, wr_issue ? m_we : 2'b00);
        chk("mem_addr",  mem_addr,  busy ? m_addr : 32'h0);
        chk("mem_wdata", mem_wdata, wr_issue ? m_wd : 32'h0);
        chk("cpu_ack",   cpu_ack,   exp_ack(1'b0));
        chk("vga_ack",   vga_ack,   exp_ack(1'b1));
        chk("owner",     owner,     m_own);
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("vga_rdata", vga_rdata, e_vrd);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic new_cpu();
        cpu_req   = 1'b1;
        cpu_we    = 2'($urandom_range(0, 3));
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
    endtask

    task automatic new_vga();
        vga_req  = 1'b1;
        vga_addr = $urandom;
    endtask

    initial begin
        int n, wrc, bad, na, t1, t2, dup;
        int seq [6];

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // CPU word write
        cpu_req = 1'b1; cpu_we = 2'b11; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF;
        n = -1; wrc = 0;
        for (int i = 1; i <= 10 && n < 0; i++) begin
            cyc();
            if (mem_write == 2'b11) wrc++;
            if (cpu_ack) n = i;
        end
        cpu_req = 1'b0;
        chk("wr_ack_latency", n, 2);
        chk("wr_pulse_cycles", wrc, 1);
        cyc();

        // CPU read, MEM_LAT cycles of memory latency
        cpu_req = 1'b1; cpu_we = 2'b00; cpu_addr = 32'h200;
        salt = 32'h12345678 ^ 32'h200;
        n = -1; bad = 0;
        for (int i = 1; i <= 20 && n < 0; i++) begin
            cyc();
            if (mem_read && mem_addr !== 32'h200) bad++;
            if (cpu_ack) begin
                n = i;
                chk("rd_data", cpu_rdata, 32'h12345678);
            end
        end
        cpu_req = 1'b0;
        chk("rd_ack_latency", n, 1 + MEM_LAT);
        chk("rd_addr_stable", bad, 0);
        cyc();

        // Simultaneous requests: VGA first, then CPU
        salt = 32'h0BAD_F00D;
        cpu_req = 1'b1; cpu_we = 2'b00; cpu_addr = 32'h300;
        vga_req = 1'b1; vga_addr = 32'h400;
        na = 0; seq = '{default: 2};
        for (int i = 0; i < 30 && na < 2; i++) begin
            cyc();
            if (cpu_ack || vga_ack) begin seq[na] = owner; na++; end
            if (cpu_ack) cpu_req = 1'b0;
            if (vga_ack) vga_req = 1'b0;
        end
        chk("simul_first_owner", seq[0], 1);
        chk("simul_second_owner", seq[1], 0);
        cyc();

        // Starvation: VGA held continuously, CPU waits
        cpu_req = 1'b1; cpu_we = 2'b01; cpu_addr = 32'h500; cpu_wdata = 32'hA5;
        new_vga();
        na = 0; seq = '{default: 2};
        for (int i = 0; i < 80 && na < 6; i++) begin
            cyc();
            if (cpu_ack || vga_ack) begin seq[na] = owner; na++; end
            if (cpu_ack) cpu_req = 1'b0;
            if (vga_ack) begin
                if (na >= 6) vga_req = 1'b0;
                else         vga_addr = $urandom;
            end
        end
        chk("starve_ack0", seq[0], 1);
        chk("starve_ack1", seq[1], 1);
        chk("starve_ack2", seq[2], 1);
        chk("starve_ack3", seq[3], 1);
        chk("starve_ack4", seq[4], 0);
        chk("starve_ack5", seq[5], 1);
        cpu_req = 1'b0; vga_req = 1'b0;
        cyc();

        // Back-to-back VGA: re-request in the IDLE cycle right after the ack
        vga_req = 1'b1; vga_addr = 32'h600;
        t1 = -1; t2 = -1; dup = 0;
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            cyc();
            if (t1 >= 0 && mem_read && mem_addr == 32'h600) dup++;
            if (vga_ack) begin
                if (t1 < 0) begin t1 = i; vga_addr = 32'h700; end
                else begin t2 = i; vga_req = 1'b0; end
            end
        end
        chk("b2b_spacing", t2 - t1, MEM_LAT + 2);
        chk("b2b_no_dup_issue", dup, 0);
        cyc();

        // Asynchronous reset in the middle of a read WAIT
        cpu_req = 1'b1; cpu_we = 2'b00; cpu_addr = 32'h800;
        cyc(); cyc();
        chk("pre_rst_in_wait", ph, 2);
        #2;
        rst = 1'b0;
        #1;
        cpu_req = 1'b0;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        na = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (cpu_ack || vga_ack) na++;
        end
        chk("post_rst_no_ack", na, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) salt = $urandom;
            cyc();
            if (cpu_req) begin
                if (exp_ack(1'b0)) begin
                    if ($urandom_range(0, 1) == 1) new_cpu();
                    else cpu_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_cpu();
            end
            if (vga_req) begin
                if (exp_ack(1'b1)) begin
                    if ($urandom_range(0, 1) == 1) new_vga();
                    else vga_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_vga();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
